// File: rtl/viterbi_pkg.sv
// Shared constants and the reference byte-encoding function for the rate-1/2, K=3
// convolutional encoder and its Viterbi decoder models.
package viterbi_pkg;

    localparam int K      = 3;
    localparam int ST_W   = K - 1;
    localparam int SYM_W  = 2;
    localparam int BYTE_W = 8;
    localparam int CW_W   = 16;

    localparam logic [K-1:0] G0_DEF = 3'b111;
    localparam logic [K-1:0] G1_DEF = 3'b101;

    // Encodes one byte MSB first from the given trellis state; returns {next_state, codeword}.
    function automatic logic [ST_W+CW_W-1:0] conv_enc_byte_f(
        input logic [ST_W-1:0]   state,
        input logic [BYTE_W-1:0] byte_in,
        input logic [K-1:0]      g0,
        input logic [K-1:0]      g1
    );
        logic [ST_W-1:0] s;
        logic [K-1:0]    r;
        logic [CW_W-1:0] cw;
        s  = state;
        cw = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            r = {byte_in[BYTE_W-1-i], s};
            cw[CW_W-1-SYM_W*i -: SYM_W] = {^(r & g0), ^(r & g1)};
            s = {byte_in[BYTE_W-1-i], s[ST_W-1]};
        end
        return {s, cw};
    endfunction

endpackage

// File: rtl/conv_enc_byte_if.sv
// Byte-in / codeword-out bus of the convolutional encoder.
// ERR_INJECT_EN adds the err_mask_i codeword error mask.
interface conv_enc_byte_if;
    import viterbi_pkg::*;

    logic              byte_valid_i;
    logic [BYTE_W-1:0] byte_i;
    logic              sof_i;
    logic              byte_ready_o;
    logic              piso_busy_i;
    logic              load_o;
    logic [CW_W-1:0]   data_parallel_o;
`ifdef ERR_INJECT_EN
    logic [CW_W-1:0]   err_mask_i;

    modport master (
        output byte_valid_i, byte_i, sof_i, piso_busy_i, err_mask_i,
        input  byte_ready_o, load_o, data_parallel_o
    );
    modport slave (
        input  byte_valid_i, byte_i, sof_i, piso_busy_i, err_mask_i,
        output byte_ready_o, load_o, data_parallel_o
    );
`else
    modport master (
        output byte_valid_i, byte_i, sof_i, piso_busy_i,
        input  byte_ready_o, load_o, data_parallel_o
    );
    modport slave (
        input  byte_valid_i, byte_i, sof_i, piso_busy_i,
        output byte_ready_o, load_o, data_parallel_o
    );
`endif

endinterface

// File: rtl/conv_enc_byte.sv
// Rate-1/2 K=3 convolutional byte encoder feeding a parallel-to-serial stage via a load strobe.
// ERR_INJECT_EN: XOR err_mask_i into the codeword at launch.
module conv_enc_byte
    import viterbi_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEF,
    parameter logic [K-1:0] G1 = G1_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    conv_enc_byte_if.slave bus
);

    logic [ST_W-1:0]      state;
    logic                 pend;
    logic                 load_p1;
    logic [CW_W-1:0]      cw_p0;
    logic [CW_W-1:0]      data_p1;
    logic [CW_W-1:0]      launch_word;
    logic [ST_W+CW_W-1:0] enc;
    logic                 ready;
    logic                 accept;
    logic                 launch;

    assign ready  = !pend && !load_p1;
    assign accept = bus.byte_valid_i && ready;
    assign launch = pend && !bus.piso_busy_i && !load_p1;
    assign enc    = conv_enc_byte_f(bus.sof_i ? '0 : state, bus.byte_i, G0, G1);

`ifdef ERR_INJECT_EN
    assign launch_word = cw_p0 ^ bus.err_mask_i;
`else
    assign launch_word = cw_p0;
`endif

    // Stage p0: accepted byte encoded and held until the serializer is free
    always_ff @(posedge clk) begin
        if (accept) begin
            cw_p0 <= enc[CW_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= '0;
            pend    <= 1'b0;
            load_p1 <= 1'b0;
            data_p1 <= '0;
        end else begin
            load_p1 <= 1'b0;
            if (accept) begin
                state <= enc[ST_W+CW_W-1:CW_W];
                pend  <= 1'b1;
            end else if (launch) begin
                pend    <= 1'b0;
                load_p1 <= 1'b1;
                data_p1 <= launch_word;
            end
        end
    end

    // Stage p1: launched codeword, held until the next launch
    assign bus.byte_ready_o    = ready;
    assign bus.load_o          = load_p1;
    assign bus.data_parallel_o = data_p1;

endmodule

// File: tb/tb_conv_enc_byte.sv
// Self-checking bench for conv_enc_byte: directed trellis cases plus a random stream
// against a bit-history reference model and a behavioural serializer.
module tb_conv_enc_byte;

    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;

    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   m_prev1 = 0;
    int   m_prev2 = 0;
    logic [15:0] exp_q[$];

    conv_enc_byte_if bus();

    conv_enc_byte dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each symbol bit is the mod-2 sum of the tapped inputs in the last three bits.
    function automatic logic [15:0] model_cw(input logic [7:0] b, input logic sof);
        logic [15:0] cw;
        int u, t1, t0;
        cw = '0;
        if (sof) begin
            m_prev1 = 0;
            m_prev2 = 0;
        end
        for (int i = 0; i < 8; i++) begin
            u  = int'(b[7-i]);
            t1 = (u * int'(G0[2]) + m_prev1 * int'(G0[1]) + m_prev2 * int'(G0[0])) % 2;
            t0 = (u * int'(G1[2]) + m_prev1 * int'(G1[1]) + m_prev2 * int'(G1[0])) % 2;
            cw[15-2*i] = (t1 != 0);
            cw[14-2*i] = (t0 != 0);
            m_prev2 = m_prev1;
            m_prev1 = u;
        end
        return cw;
    endfunction

    task automatic model_reset();
        m_prev1 = 0;
        m_prev2 = 0;
    endtask

    // Offers one byte and returns just after the accepting edge.
    task automatic put_byte(input logic [7:0] b, input logic s);
        int n;
        n = 0;
        @(negedge clk);
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = b;
        bus.sof_i        = s;
        while (!bus.byte_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: byte %h not accepted after %0d cycles", b, n);
        end
        exp_q.push_back(model_cw(b, s));
        @(posedge clk);
        #1;
        bus.byte_valid_i = 1'b0;
        bus.sof_i        = 1'b0;
    endtask

    task automatic wait_load(output logic [15:0] d, output int lat);
        lat = 0;
        d   = '0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.load_o) begin
                d = bus.data_parallel_o;
                return;
            end
        end
        n_cmp++;
        n_fail++;
        $display("FAIL load_timeout: no load_o within %0d cycles", lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.load_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_load: got %b want 0", bus.load_o);
        end
        n_cmp++;
        if (bus.data_parallel_o !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0000", bus.data_parallel_o);
        end
        n_cmp++;
        if (bus.byte_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", bus.byte_ready_o);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [15:0] d;
        int lat;
        bus.piso_busy_i = 1'b0;
        put_byte(8'h80, 1'b1);
        wait_load(d, lat);
        n_cmp++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL single_latency: got %0d negedges want 2", lat);
        end
        n_cmp++;
        if (d !== 16'hEC00) begin
            n_fail++;
            $display("FAIL single_cw: got %h want EC00", d);
        end
        n_cmp++;
        if (bus.byte_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready_during_load: got %b want 0", bus.byte_ready_o);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.load_o !== 1'b0 || bus.data_parallel_o !== 16'hEC00) begin
            n_fail++;
            $display("FAIL single_pulse: load %b data %h want load 0 data EC00", bus.load_o, bus.data_parallel_o);
        end
        // final state 00: same byte without sof encodes identically
        put_byte(8'h80, 1'b0);
        wait_load(d, lat);
        n_cmp++;
        if (d !== 16'hEC00) begin
            n_fail++;
            $display("FAIL single_state00: got %h want EC00", d);
        end
    endtask

    task automatic test_state_carry();
        logic [15:0] d;
        int lat;
        logic [15:0] want [4];
        logic [7:0]  bytes [4];
        logic        sofs [4];
        want  = '{16'hDAAA, 16'h7000, 16'hDAAA, 16'h0000};
        bytes = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        sofs  = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            put_byte(bytes[i], sofs[i]);
            wait_load(d, lat);
            n_cmp++;
            if (d !== want[i]) begin
                n_fail++;
                $display("FAIL carry_cw%0d: got %h want %h", i, d, want[i]);
            end
        end
    endtask

    task automatic test_busy_hold();
        logic [15:0] e;
        logic [7:0]  b;
        int bad_load, bad_ready;
        exp_q.delete();
        bad_load  = 0;
        bad_ready = 0;
        b = 8'($urandom);
        bus.piso_busy_i = 1'b1;
        put_byte(b, 1'b1);
        e = exp_q.pop_front();
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.load_o !== 1'b0) bad_load++;
            if (bus.byte_ready_o !== 1'b0) bad_ready++;
        end
        bus.byte_valid_i = 1'b0;
        n_cmp++;
        if (bad_load != 0) begin
            n_fail++;
            $display("FAIL busy_load: load_o high in %0d of 20 busy cycles, want 0", bad_load);
        end
        n_cmp++;
        if (bad_ready != 0) begin
            n_fail++;
            $display("FAIL busy_ready: byte_ready_o high in %0d of 20 busy cycles, want 0", bad_ready);
        end
        bus.piso_busy_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.load_o !== 1'b1 || bus.data_parallel_o !== e) begin
            n_fail++;
            $display("FAIL busy_release: load %b data %h want load 1 data %h", bus.load_o, bus.data_parallel_o, e);
        end
        bad_load = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.load_o !== 1'b0) bad_load++;
        end
        n_cmp++;
        if (bad_load != 0) begin
            n_fail++;
            $display("FAIL busy_duplicate: %0d extra loads, want 0", bad_load);
        end
    endtask

    task automatic test_back_to_back();
        int seen, cyc, bcnt;
        logic prev_load;
        logic [15:0] e;
        exp_q.delete();
        seen = 0;
        cyc  = 0;
        bcnt = 0;
        prev_load = 1'b0;
        bus.piso_busy_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    put_byte(8'($urandom), (i == 0) || ($urandom_range(0, 3) == 0));
                end
            end
            begin
                while (seen < 16 && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    if (bus.load_o) begin
                        n_cmp++;
                        if (prev_load || bus.piso_busy_i) begin
                            n_fail++;
                            $display("FAIL b2b_protocol: load #%0d prev_load %b busy %b want both 0", seen, prev_load, bus.piso_busy_i);
                        end
                        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                        n_cmp++;
                        if (bus.data_parallel_o !== e) begin
                            n_fail++;
                            $display("FAIL b2b_cw%0d: got %h want %h", seen, bus.data_parallel_o, e);
                        end
                        seen++;
                        bus.piso_busy_i = 1'b1;
                        bcnt = 8;
                    end else if (bcnt > 0) begin
                        bcnt--;
                        if (bcnt == 0) bus.piso_busy_i = 1'b0;
                    end
                    prev_load = bus.load_o;
                end
                n_cmp++;
                if (seen != 16) begin
                    n_fail++;
                    $display("FAIL b2b_count: got %0d codewords want 16", seen);
                end
            end
        join
        bus.piso_busy_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_pending();
        logic [15:0] d;
        int lat, bad;
        bus.piso_busy_i = 1'b1;
        put_byte(8'h5A, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.load_o !== 1'b0 || bus.data_parallel_o !== 16'h0000 || bus.byte_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pend: load %b data %h ready %b want 0 0000 1", bus.load_o, bus.data_parallel_o, bus.byte_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        bus.piso_busy_i = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.load_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rst_dropped: %0d loads after reset, want 0", bad);
        end
        put_byte(8'hFF, 1'b1);
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.load_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_load_pre: load %b want 1", bus.load_o);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.load_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_load_async: load %b want 0", bus.load_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        put_byte(8'h80, 1'b0);
        wait_load(d, lat);
        n_cmp++;
        if (d !== 16'hEC00) begin
            n_fail++;
            $display("FAIL rst_state: got %h want EC00", d);
        end
    endtask

`ifdef ERR_INJECT_EN
    task automatic test_err_inject();
        logic [15:0] d;
        int lat;
        bus.err_mask_i = 16'h0001;
        put_byte(8'h80, 1'b1);
        wait_load(d, lat);
        bus.err_mask_i = 16'h0000;
        n_cmp++;
        if (d !== 16'hEC01) begin
            n_fail++;
            $display("FAIL err_inject: got %h want EC01", d);
        end
        put_byte(8'h00, 1'b0);
        wait_load(d, lat);
        n_cmp++;
        if (d !== 16'h0000) begin
            n_fail++;
            $display("FAIL err_state: got %h want 0000", d);
        end
    endtask
`endif

    initial begin
        rst_n            = 1'b0;
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = '0;
        bus.sof_i        = 1'b0;
        bus.piso_busy_i  = 1'b0;
`ifdef ERR_INJECT_EN
        bus.err_mask_i   = '0;
`endif
        test_reset();
        test_single();
        test_state_carry();
        test_busy_hold();
        test_back_to_back();
        test_reset_pending();
`ifdef ERR_INJECT_EN
        test_err_inject();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_enc_byte.md
Name: conv_enc_byte

Overview:
Rate-1/2 convolutional encoder for the Viterbi decoder test path.
- Accepts one byte per valid/ready handshake and encodes its 8 bits MSB first.
- Produces a 16-bit codeword of 8 two-bit symbols, first symbol in [15:14].
- Drives the downstream parallel-to-serial stage through a single-cycle load pulse, gated by that stage's busy flag.
- Encoder trellis state persists across bytes within a frame and is cleared at start of frame.

Parameters:
- G0, 3'b111, generator polynomial for symbol bit 1 (octal 7); bit 2 taps the current input.
- G1, 3'b101, generator polynomial for symbol bit 0 (octal 5).
- K is fixed at 3 (constraint length; 2 state bits) and lives in the package, not here.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- byte_valid_i  in  1  input byte valid
- byte_i  in  8  input byte, bit 7 encoded first
- sof_i  in  1  start of frame; qualified by byte_valid_i && byte_ready_o
- byte_ready_o  out  1  encoder can accept a byte
- piso_busy_i  in  1  downstream serializer busy
- load_o  out  1  single-cycle load strobe to serializer
- data_parallel_o  out  16  codeword, valid while load_o=1
- err_mask_i  in  16  error mask, present only with ERR_INJECT_EN

Behaviour:
- Reset values (async, rst_n=0): load_o=0, data_parallel_o=0, state=2'b00, pend=0. A held codeword is dropped.
- byte_ready_o = !pend && !load_o (combinational).
- Accept occurs when byte_valid_i && byte_ready_o at a rising edge. On accept:
  - Start state s = sof_i ? 2'b00 : state.
  - Per bit u, MSB first, with r = {u, s[1], s[0]}:
    - c1 = ^(r & G0), c0 = ^(r & G1)
    - symbol = {c1, c0}
    - s_next = {u, s[1]}
  - Symbol i (i = 0 for bit 7) goes to cw[15-2i : 14-2i].
  - cw and the final s are registered; pend <= 1.
- Launch: when pend && !piso_busy_i && !load_o, then load_o <= 1, data_parallel_o <= cw, pend <= 0.
  - load_o is high for exactly one cycle; never two consecutive cycles.
  - data_parallel_o holds its value until the next launch.
- Latency: accept at edge T gives load_o high in cycle T+1 if piso_busy_i=0 at edge T+1. Otherwise it waits.
- A new byte may be accepted from the cycle after load_o deasserts; the next codeword is held until busy falls.
- piso_busy_i high for any number of cycles: pend holds, and byte_valid_i is back-pressured.
- Encoder state is updated only on accept; a launch never alters it.
- A sof_i without valid is ignored.

Optional Feature:
ERR_INJECT_EN:
- Defined: port err_mask_i exists, and data_parallel_o <= cw ^ err_mask_i, sampled at the launch edge. The encoder state is unaffected. Used for bit-error-rate and decoder-correction tests.
- Undefined: port absent, and data_parallel_o <= cw.

Decomposition:
- Shared package viterbi_pkg:
  - Constants K=3, SYM_W=2, BYTE_W=8, CW_W=16, default G0/G1.
  - Function conv_enc_byte_f(state, byte, g0, g1) returning {next_state, codeword}. The decoder reference model in the bench reuses it.
- No sub-module: the datapath is a single registered function call plus a 2-flag handshake controller.

Test Plan:
1. Reset, then byte 8'h80 with sof_i=1 and piso_busy_i=0 -> load_o pulses 1 cycle after accept, data_parallel_o=16'hEC00, final state 00.
2. Byte 8'hFF with sof_i=1, then 8'h00 with sof_i=0 -> codewords 16'hDAAA then 16'h7000. Repeating the pair with sof_i=1 on the second byte -> 16'hDAAA then 16'h0000.
3. Hold piso_busy_i=1 for 20 cycles after an accept:
   - load_o stays 0 and byte_ready_o stays 0.
   - Deassert busy -> load_o pulses the cycle after, with the correct codeword; no byte lost or duplicated.
4. Back-to-back stream of 16 random bytes against a behavioural serializer (busy 8 cycles after each load):
   - Every codeword matches the package function.
   - load_o never high on consecutive cycles or while busy.
5. Assert rst_n=0 while pend=1 -> load_o=0 immediately, no launch after release, state restarts at 00 (8'h80 without sof -> 16'hEC00).
6. With ERR_INJECT_EN defined, err_mask_i=16'h0001 on byte 8'h80 with sof -> data_parallel_o=16'hEC01; next byte 8'h00 -> 16'h0000 (state unaffected).
